// File: rtl/fetch_pkg.sv
// Shared constants, entry type and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} entries; any DEPTH >= 2, flush overrides push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               head_valid_o,
  output fetch_entry_t       head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem reads,
// prefetch buffering and redirect flush. Optional counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_delivered,
  output logic [31:0] perf_bubble
`endif
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W:0]   credit_s;
  logic             head_valid_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_data_s;
  logic             pop_s, push_s, issue_s;

  // Occupancy after this cycle's pop must leave room for the new request's data.
  always_comb begin
    pop_s       = head_valid_s & inst_ready & ~redirect_valid;
    push_s      = pend_q & ~redirect_valid;
    push_data_s = '{pc: pend_pc_q, inst: imem_rdata};
    credit_s    = {1'b0, count_s} + {{CNT_W{1'b0}}, pend_q} - {{CNT_W{1'b0}}, pop_s};
    issue_s     = ~rst & ~redirect_valid & (credit_s < (CNT_W + 1)'(DEPTH));
  end

  always_comb begin
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    if (redirect_valid) begin
      pc_d   = align_word(redirect_pc);
      pend_d = 1'b0;
    end else if (issue_s) begin
      pc_d      = pc_q + PC_STEP;
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
    end else begin
      pc_d   = pc_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= align_word(RESET_PC);
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (redirect_valid),
    .push_i       (push_s),
    .push_data_i  (push_data_s),
    .pop_i        (pop_s),
    .count_o      (count_s),
    .head_valid_o (head_valid_s),
    .head_o       (head_s)
  );

  assign imem_req   = issue_s;
  assign imem_addr  = align_word(pc_q);
  assign inst_valid = head_valid_s;
  assign inst       = head_valid_s ? head_s.inst : NOP_INST;
  assign inst_pc    = head_valid_s ? head_s.pc : 32'h0000_0000;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_delivered_q, perf_bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_delivered_q <= '0;
      perf_bubble_q    <= '0;
    end else begin
      perf_delivered_q <= perf_delivered_q + {31'd0, pop_s};
      perf_bubble_q    <= perf_bubble_q + {31'd0, (inst_ready & ~head_valid_s)};
    end
  end

  assign perf_delivered = perf_delivered_q;
  assign perf_bubble    = perf_bubble_q;
`endif

endmodule
